// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: valid/ready byte intake into a small FIFO,
// serialized LSB-first with back-to-back frames when the FIFO has more work.
module uart_tx #(
  parameter int CLKS_PER_BIT = 28,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [7:0]                  i_data,
  input  logic                        i_valid,
  output logic                        o_ready,
  output logic                        o_tx,
  output logic                        o_busy,
  output logic [$clog2(FIFO_DEPTH):0] o_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [BW-1:0] baud;
  logic [2:0]    idx;
  logic [9:0]    shreg;
  logic          push, pop, bit_end, count_nz, frame_next;
  logic [CW-1:0] count_next;

  assign o_ready  = !i_rst && (o_count != FULL);
  assign push     = i_valid && o_ready;
  assign count_nz = (o_count != '0);
  assign bit_end  = (baud == BAUD_LAST);
  // Pops happen from IDLE, or on the last stop-bit cycle so frames abut with no gap
  assign pop      = count_nz && ((state == IDLE) || (state == STOP && bit_end));
  assign frame_next = pop || !((state == IDLE) || (state == STOP && bit_end));

  always_comb begin
    count_next = o_count;
    if (push && !pop)      count_next = o_count + 1'b1;
    else if (pop && !push) count_next = o_count - 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wptr] <= i_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      o_tx    <= 1'b1;
      o_busy  <= 1'b0;
      o_count <= '0;
      wptr    <= '0;
      rptr    <= '0;
      baud    <= '0;
      idx     <= '0;
      shreg   <= '1;
    end else begin
      o_count <= count_next;
      o_busy  <= frame_next || (count_next != '0);
      if (push) wptr <= wptr + 1'b1;
      if (pop) begin
        rptr  <= rptr + 1'b1;
        shreg <= {1'b1, mem[rptr], 1'b0};
      end
      baud <= bit_end ? '0 : baud + 1'b1;
      case (state)
        IDLE: begin
          baud <= '0;
          if (pop) begin
            state <= START;
            o_tx  <= 1'b0;
          end else begin
            o_tx  <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state <= DATA;
            idx   <= '0;
            shreg <= {1'b1, shreg[9:1]};
            o_tx  <= shreg[1];
          end
        end
        DATA: begin
          if (bit_end) begin
            shreg <= {1'b1, shreg[9:1]};
            o_tx  <= shreg[1];
            idx   <= idx + 1'b1;
            if (idx == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (pop) begin
              state <= START;
              o_tx  <= 1'b0;
            end else begin
              state <= IDLE;
              o_tx  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/uart_tx.md
# uart_tx

Buffered 8N1 UART transmitter, the sending end of the serial link whose receiver feeds the controller parser. It accepts bytes over a valid/ready handshake into a small FIFO and serializes them LSB-first on a single output pin, such as a GPIO line back to the controller MCU (status, acks, haptics). It runs on the same UART clock as the receiver. The default divider yields 115200 baud from 3.2258 MHz.

## Interface
- CLKS_PER_BIT, default 28: clock cycles per serial bit. Must be ≥ 2.
- FIFO_DEPTH, default 4: byte buffer entries. Must be a power of two, ≥ 2.
- i_clk  input  1  UART clock; all logic on its rising edge.
- i_rst  input  1  reset; synchronous, active-high.
- i_data  input  8  byte to send; sampled when i_valid && o_ready.
- i_valid  input  1  producer holds a byte on i_data.
- o_ready  output  1  = !i_rst && (count != FIFO_DEPTH); combinational.
- o_tx  output  1  serial line; registered; idle high.
- o_busy  output  1  registered; high while a frame is on the line or the FIFO is non-empty.
- o_count  output  $clog2(FIFO_DEPTH)+1  bytes currently in the FIFO; excludes the byte in the shifter.

## Operation
- Reset values: o_tx=1, o_busy=0, o_count=0, FSM=IDLE, FIFO pointers=0. o_ready is 0 while i_rst is high and 1 after reset.
- Push: when i_valid && o_ready, i_data is written at the write pointer. Pointers wrap modulo FIFO_DEPTH. A full FIFO never accepts a byte.
- Pop: the FSM reads the head byte into a 10-bit shift register {1, data, 0} and advances the read pointer.
- Simultaneous push and pop: count is unchanged, and both pointers advance.
- No bypass: a byte always passes through the FIFO, even when the block is idle.
- FSM states:
  - IDLE: o_tx=1. If count≠0, pop and go to START.
  - START: o_tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: o_tx=data[idx] for CLKS_PER_BIT cycles per bit, LSB first. After idx 7, go to STOP.
  - STOP: o_tx=1 for CLKS_PER_BIT cycles. On the last cycle, if count≠0, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1, is cleared on every state entry, and wraps at each bit boundary. Width is $clog2(CLKS_PER_BIT).
- Reset mid-frame: aborts the frame, drives o_tx=1 on the next edge, and discards FIFO contents. No partial stop bit is emitted.
- o_busy = (FSM≠IDLE) || (count≠0), registered from next-state values.

## Timing
- Byte accepted at edge E into an empty FIFO with the FSM in IDLE:
  - o_count=1 after E.
  - Pop at E+1; o_tx falls after E+1.
  - o_count returns to 0 after E+1.
- Frame length: exactly 10×CLKS_PER_BIT cycles of line time (start + 8 data + stop).
- Back-to-back frames: the next start bit begins on the cycle immediately after the last stop-bit cycle.
- Sustained throughput: one byte per 10×CLKS_PER_BIT cycles.
- A pop on the full-FIFO cycle raises o_ready on the following cycle. There is no same-cycle push into the freed slot.
- i_data and i_valid may change freely when o_ready=0. A byte is accepted only on a handshake edge.

## Test plan
- CLKS_PER_BIT=4, send 0x55:
  - o_tx is low 4 cycles, then 1,0,1,0,1,0,1,0 with 4 cycles each, then high 4 cycles.
  - o_busy is high for 40 cycles plus the 1-cycle pop latency, then low.
- Send 0x00 then 0xFF back-to-back:
  - 80 contiguous line cycles, with no idle-high gap between the first stop bit and the second start bit.
  - Data bits all 0 in the first frame, all 1 in the second.
- Hold i_valid high with bytes 0x01..0x06 at FIFO_DEPTH=4:
  - Byte 0x01 is popped immediately, and 0x02..0x05 fill the FIFO (o_count=4, o_ready=0).
  - 0x06 is held until the first pop.
  - Line output is 0x01..0x06 in order, with no loss or duplication.
- Assert i_rst for 1 cycle during DATA bit 3 with 2 bytes queued:
  - After the next edge, o_tx=1, o_count=0, o_busy=0, o_ready=1.
  - No further start bit appears.
- Push 0xA5 while o_ready=0 (FIFO full):
  - The byte is not stored; o_count stays 4.
  - The next accepted byte is transmitted in its FIFO order.
- Loopback into the receiver, default parameters, 256 random bytes: every byte is received with valid pulsed once and matching data_out.
